conv1_frame_ctrl: RTL and testbench

//  Frame sequencer for the first conv layer. On start it clears the conv1 line buffer,

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/conv1_frame_ctrl_if.sv | 41 ++++
 rtl/conv1_fm_capture.sv | 53 +++++
 rtl/conv1_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_conv1_frame_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: image geometry, bus widths and the FSM state encoding
// shared by the layer frame controllers.
package cnn_pkg;

    localparam int IMG_W     = 28;
    localparam int IMG_H     = 28;
    localparam int K         = 5;
    localparam int DATA_BITS = 8;
    localparam int OUT_BITS  = 15;
    localparam int ADDR_BITS = 10;

    localparam int N_PIX = IMG_W * IMG_H;
    localparam int N_OUT = (IMG_H - K + 1) * (IMG_W - K + 1);

    localparam logic [ADDR_BITS-1:0] PIX_LAST = ADDR_BITS'(N_PIX - 1);
    localparam logic [ADDR_BITS-1:0] OUT_FULL = ADDR_BITS'(N_OUT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_CLR   = 3'b001,
        ST_FEED  = 3'b010,
        ST_DRAIN = 3'b011,
        ST_DONE  = 3'b100
    } state_t;

endpackage

// File: rtl/conv1_frame_ctrl_if.sv
// conv1_frame_ctrl_if: image RAM read port, conv1 layer stream and
// feature-map write port seen by the frame controller.
interface conv1_frame_ctrl_if;
    import cnn_pkg::*;

    logic                 img_rd_en;
    logic [ADDR_BITS-1:0] img_addr;
    logic [DATA_BITS-1:0] img_data;

    logic                 layer_rst_n;
    logic [DATA_BITS-1:0] layer_data_in;
    logic                 layer_valid_out;
    logic [OUT_BITS-1:0]  layer_out_1;
    logic [OUT_BITS-1:0]  layer_out_2;
    logic [OUT_BITS-1:0]  layer_out_3;

    logic                 fm_wr_en;
    logic [ADDR_BITS-1:0] fm_wr_addr;
    logic [OUT_BITS-1:0]  fm_wr_data_1;
    logic [OUT_BITS-1:0]  fm_wr_data_2;
    logic [OUT_BITS-1:0]  fm_wr_data_3;

    modport master (
        output img_rd_en, img_addr,
        input  img_data,
        output layer_rst_n, layer_data_in,
        input  layer_valid_out, layer_out_1, layer_out_2, layer_out_3,
        output fm_wr_en, fm_wr_addr,
        output fm_wr_data_1, fm_wr_data_2, fm_wr_data_3
    );

    modport slave (
        input  img_rd_en, img_addr,
        output img_data,
        input  layer_rst_n, layer_data_in,
        output layer_valid_out, layer_out_1, layer_out_2, layer_out_3,
        input  fm_wr_en, fm_wr_addr,
        input  fm_wr_data_1, fm_wr_data_2, fm_wr_data_3
    );

endinterface

// File: rtl/conv1_fm_capture.sv
// conv1_fm_capture: registers each conv1 result into a feature-map
// write, counts results and flags any result beyond the last slot.
module conv1_fm_capture
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 active,
    input  logic                 valid,
    input  logic [OUT_BITS-1:0]  d1,
    input  logic [OUT_BITS-1:0]  d2,
    input  logic [OUT_BITS-1:0]  d3,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [OUT_BITS-1:0]  wr_d1,
    output logic [OUT_BITS-1:0]  wr_d2,
    output logic [OUT_BITS-1:0]  wr_d3,
    output logic [ADDR_BITS-1:0] out_cnt,
    output logic                 overrun
);

    // One write per accepted result; extras only raise the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_d1   <= '0;
            wr_d2   <= '0;
            wr_d3   <= '0;
            out_cnt <= '0;
            overrun <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                out_cnt <= '0;
                overrun <= 1'b0;
            end else if (active && valid) begin
                if (out_cnt < OUT_FULL) begin
                    wr_en   <= 1'b1;
                    wr_addr <= out_cnt;
                    wr_d1   <= d1;
                    wr_d2   <= d2;
                    wr_d3   <= d3;
                    out_cnt <= out_cnt + 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv1_frame_ctrl.sv
// conv1_frame_ctrl: clears conv1, streams one image gaplessly into it,
// collects its results into the feature map and reports done/errors.
module conv1_frame_ctrl
    import cnn_pkg::*;
#(
    parameter int CLR_CYC  = 2,
    parameter int DRAIN_TO = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err_timeout,
    output logic err_overrun,
    conv1_frame_ctrl_if.master bus
);

    localparam int CW = $clog2(CLR_CYC + 1);
    localparam int TW = $clog2(DRAIN_TO + 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(DRAIN_TO - 1);

    state_t               state;
    state_t               state_nx;
    logic                 go;
    logic                 tmo;
    logic                 active;
    logic [CW-1:0]        clr_cnt;
    logic [TW-1:0]        idle_cnt;
    logic [ADDR_BITS-1:0] pix_cnt;
    logic [ADDR_BITS-1:0] out_cnt;
    logic                 rd_vld_d;
    logic [DATA_BITS-1:0] pix_q;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [OUT_BITS-1:0]  wr_d1;
    logic [OUT_BITS-1:0]  wr_d2;
    logic [OUT_BITS-1:0]  wr_d3;

    assign active = (state == ST_FEED) || (state == ST_DRAIN);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    assign bus.img_rd_en     = (state == ST_FEED);
    assign bus.img_addr      = (state == ST_FEED) ? pix_cnt : '0;
    assign bus.layer_rst_n   = active;
    assign bus.layer_data_in = pix_q;
    assign bus.fm_wr_en      = wr_en;
    assign bus.fm_wr_addr    = wr_addr;
    assign bus.fm_wr_data_1  = wr_d1;
    assign bus.fm_wr_data_2  = wr_d2;
    assign bus.fm_wr_data_3  = wr_d3;

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next state; a completed capture count wins over a same-cycle timeout.
    always_comb begin
        state_nx = state;
        go       = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_CLR;
                    go       = 1'b1;
                end
            end
            ST_CLR: begin
                if (clr_cnt == CLR_LAST) state_nx = ST_FEED;
            end
            ST_FEED: begin
                if (pix_cnt == PIX_LAST) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_cnt == OUT_FULL) begin
                    state_nx = ST_DONE;
                end else if (!bus.layer_valid_out && idle_cnt == TO_LAST) begin
                    state_nx = ST_DONE;
                    tmo      = 1'b1;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Clear, pixel and drain-idle counters plus the sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt     <= '0;
            pix_cnt     <= '0;
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ST_CLR) clr_cnt <= clr_cnt + 1'b1;
            else                 clr_cnt <= '0;
            if (go)
                pix_cnt <= '0;
            else if (state == ST_FEED && pix_cnt != PIX_LAST)
                pix_cnt <= pix_cnt + 1'b1;
            if (state == ST_DRAIN && !bus.layer_valid_out)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;
            if (go)       err_timeout <= 1'b0;
            else if (tmo) err_timeout <= 1'b1;
        end
    end

    // RAM data lands one cycle after the read; register it onto the layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_d <= 1'b0;
            pix_q    <= '0;
        end else begin
            rd_vld_d <= bus.img_rd_en;
            pix_q    <= rd_vld_d ? bus.img_data : '0;
        end
    end

    conv1_fm_capture u_cap (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (go),
        .active  (active),
        .valid   (bus.layer_valid_out),
        .d1      (bus.layer_out_1),
        .d2      (bus.layer_out_2),
        .d3      (bus.layer_out_3),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_d1   (wr_d1),
        .wr_d2   (wr_d2),
        .wr_d3   (wr_d3),
        .out_cnt (out_cnt),
        .overrun (err_overrun)
    );

endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// tb_conv1_frame_ctrl: ramp image RAM plus a behavioural conv1 model
// driving directed frames through the frame controller.
module tb_conv1_frame_ctrl;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic err_timeout;
    logic err_overrun;

    conv1_frame_ctrl_if bus ();

    conv1_frame_ctrl #(
        .CLR_CYC  (2),
        .DRAIN_TO (256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lcnt = 0;
    int emitted, max_v;
    bit extra, extra_done;
    int nwr, last_addr, done_cyc, last_wr_cyc, feed_idx, feed_end;
    int n0;
    bit ab;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_BITS-1:0] mdl(input int e, input int ch);
        return OUT_BITS'((e * 37 + ch * 5003) % 32768);
    endfunction

    task automatic emit();
        bus.layer_valid_out = 1'b1;
        bus.layer_out_1 = mdl(emitted, 1);
        bus.layer_out_2 = mdl(emitted, 2);
        bus.layer_out_3 = mdl(emitted, 3);
        emitted++;
    endtask

    task automatic tick();
        logic s_rd;
        logic [ADDR_BITS-1:0] s_addr;
        int idx, p;
        s_rd = bus.img_rd_en;
        s_addr = bus.img_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.fm_wr_en === 1'b1) begin
            chk("wr_addr", bus.fm_wr_addr, nwr);
            chk("wr_in_range", 32'(nwr < N_OUT), 1);
            chk("wr_d1", bus.fm_wr_data_1, mdl(nwr, 1));
            chk("wr_d2", bus.fm_wr_data_2, mdl(nwr, 2));
            chk("wr_d3", bus.fm_wr_data_3, mdl(nwr, 3));
            last_addr = int'(bus.fm_wr_addr);
            nwr++;
            last_wr_cyc = cyc;
        end
        if (done === 1'b1) done_cyc = cyc;
        if (bus.img_rd_en === 1'b1) begin
            chk("img_addr", bus.img_addr, feed_idx);
            feed_idx++;
            feed_end = cyc;
        end
        bus.img_data = (s_rd === 1'b1) ? s_addr[7:0] : '0;
        bus.layer_valid_out = 1'b0;
        if (bus.layer_rst_n === 1'b1) begin
            idx = lcnt;
            lcnt++;
            if (idx >= 2 && idx <= N_PIX + 1) begin
                p = idx - 2;
                chk("pixel", bus.layer_data_in, p % 256);
                if (p / IMG_W >= K - 1 && p % IMG_W >= K - 1 && emitted < max_v)
                    emit();
            end else if (extra && !extra_done && emitted == N_OUT) begin
                emit();
                extra_done = 1'b1;
            end
        end else begin
            lcnt = 0;
        end
    endtask

    task automatic run_frame(input int mv, input bit ex, input bit hold,
                             input int stop_at, input int pulse_at,
                             output bit aborted);
        bit ok;
        int clr_cyc;
        int feed_start;
        emitted = 0; max_v = mv; extra = ex; extra_done = 1'b0;
        nwr = 0; last_addr = -1; done_cyc = -1; last_wr_cyc = -1;
        feed_idx = 0; feed_end = -1; feed_start = -1;
        aborted = 1'b0; ok = 1'b0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        clr_cyc = cyc;
        chk("busy_start", busy, 1);
        chk("err_clear", {err_timeout, err_overrun}, 0);
        for (int i = 0; i < 3000; i++) begin
            if (start === 1'b1 && !hold) start = 1'b0;
            tick();
            if (feed_start < 0 && bus.img_rd_en === 1'b1) feed_start = cyc;
            chk("busy_frame", busy, 1);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (bus.img_rd_en === 1'b1 && int'(bus.img_addr) == stop_at) begin
                aborted = 1'b1;
                break;
            end
            if (bus.img_rd_en === 1'b1 && int'(bus.img_addr) == pulse_at)
                start = 1'b1;
        end
        if (!aborted) begin
            chk("done_seen", done, 1);
            chk("clr_len", feed_start, clr_cyc + 2);
            chk("feed_len", feed_idx, N_PIX);
        end
    endtask

    task automatic post(input int nw, input int la, input bit tmo, input bit ovr);
        chk("n_writes", nwr, nw);
        chk("last_addr", last_addr, la);
        chk("err_timeout", err_timeout, tmo);
        chk("err_overrun", err_overrun, ovr);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bus.img_data = '0;
        bus.layer_valid_out = 1'b0;
        bus.layer_out_1 = '0;
        bus.layer_out_2 = '0;
        bus.layer_out_3 = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", err_timeout, 0);
        chk("rst_ovr", err_overrun, 0);
        chk("rst_rd_en", bus.img_rd_en, 0);
        chk("rst_img_addr", bus.img_addr, 0);
        chk("rst_layer_rst_n", bus.layer_rst_n, 0);
        chk("rst_layer_data", bus.layer_data_in, 0);
        chk("rst_wr_en", bus.fm_wr_en, 0);
        chk("rst_wr_addr", bus.fm_wr_addr, 0);
        chk("rst_wr_d1", bus.fm_wr_data_1, 0);
        chk("rst_wr_d2", bus.fm_wr_data_2, 0);
        chk("rst_wr_d3", bus.fm_wr_data_3, 0);
        #2 rst_n = 1'b1;
        tick();

        run_frame(N_OUT, 0, 0, -1, -1, ab);
        post(N_OUT, N_OUT - 1, 0, 0);
        chk("done_after_wr", done_cyc, last_wr_cyc + 1);
        tick();
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_layer_rst", bus.layer_rst_n, 0);

        run_frame(500, 0, 0, -1, -1, ab);
        post(500, 499, 1, 0);
        chk("tmo_len", done_cyc, feed_end + 257);
        tick();
        chk("tmo_sticky", err_timeout, 1);

        run_frame(N_OUT, 1, 0, -1, -1, ab);
        post(N_OUT, N_OUT - 1, 0, 1);
        chk("ovr_done_timing", done_cyc, last_wr_cyc + 1);
        tick();
        chk("ovr_sticky", err_overrun, 1);

        run_frame(N_OUT, 0, 1, -1, -1, ab);
        post(N_OUT, N_OUT - 1, 0, 0);
        tick();
        chk("gap_idle", busy, 0);
        run_frame(N_OUT, 0, 0, -1, 100, ab);
        post(N_OUT, N_OUT - 1, 0, 0);
        tick();
        chk("pulse_idle", busy, 0);

        run_frame(N_OUT, 0, 0, 300, -1, ab);
        chk("reached_300", ab, 1);
        n0 = nwr;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_layer_rst", bus.layer_rst_n, 0);
        chk("arst_rd_en", bus.img_rd_en, 0);
        chk("arst_wr_en", bus.fm_wr_en, 0);
        tick();
        tick();
        tick();
        chk("no_wr_in_rst", nwr, n0);
        rst_n = 1'b1;
        tick();
        run_frame(N_OUT, 0, 0, -1, -1, ab);
        post(N_OUT, N_OUT - 1, 0, 0);
        chk("rst_frame_done", done_cyc, last_wr_cyc + 1);
        tick();
        chk("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
